light_sequencer: RTL and testbench



---
 rtl/light_seq_pkg.sv | 40 ++++
 rtl/phase_timer.sv | 38 +++
 rtl/light_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_light_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/light_seq_pkg.sv
// Shared types and constants for the light_sequencer block.
package light_seq_pkg;

  localparam int unsigned DefTimerW = 6;
  localparam int unsigned DefRoundW = 4;

  typedef enum logic [2:0] {
    StIdle,
    StGreen,
    StYellow,
    StRed,
    StDone
  } state_e;

  localparam logic [1:0] PH_NONE   = 2'd0;
  localparam logic [1:0] PH_GREEN  = 2'd1;
  localparam logic [1:0] PH_YELLOW = 2'd2;
  localparam logic [1:0] PH_RED    = 2'd3;

  // Bit positions inside alarm_flags, {deception_out, a3, a2, a1}.
  localparam int unsigned AlarmIdxA1  = 0;
  localparam int unsigned AlarmIdxA2  = 1;
  localparam int unsigned AlarmIdxA3  = 2;
  localparam int unsigned AlarmIdxDec = 3;

  // First phase after cur with a nonzero length, in green/yellow/red order.
  // nz is {red, yellow, green} nonzero. cur == StIdle means "start of a round".
  // Returns StDone when no later phase remains in the current round.
  function automatic state_e next_phase(input state_e cur, input logic [2:0] nz);
    next_phase = StDone;
    if ((cur == StIdle) && nz[0]) begin
      next_phase = StGreen;
    end else if (((cur == StIdle) || (cur == StGreen)) && nz[1]) begin
      next_phase = StYellow;
    end else if ((cur != StRed) && (cur != StDone) && nz[2]) begin
      next_phase = StRed;
    end
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Down-counter that times one light phase. Loading length-1 on phase entry makes
// expire assert in the phase's last cycle; the count saturates at zero.
module phase_timer
  import light_seq_pkg::*;
#(
  parameter int unsigned TIMER_W = DefTimerW
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               expire
);

  logic [TIMER_W-1:0] count_q, count_d;

  // Load on phase entry, otherwise count down and hold at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - TIMER_W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == '0);

endmodule

// File: rtl/light_sequencer.sv
// Timed green/yellow/red stimulus sequencer with sticky alarm capture.
// Optional build macro LIGHT_SEQ_ABORT_ON_ALARM_EN: any alarm while busy ends the
// sequence early through DONE and sets aborted.
module light_sequencer
  import light_seq_pkg::*;
#(
  parameter int unsigned TIMER_W = DefTimerW,
  parameter int unsigned ROUND_W = DefRoundW
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [TIMER_W-1:0] green_len,
  input  logic [TIMER_W-1:0] yellow_len,
  input  logic [TIMER_W-1:0] red_len,
  input  logic [ROUND_W-1:0] rounds,
  input  logic               a1,
  input  logic               a2,
  input  logic               a3,
  input  logic               deception_out,
  output logic               green,
  output logic               yellow,
  output logic               red,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [3:0]         alarm_flags,
  output logic [1:0]         phase
);

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] g_len_q, g_len_d, y_len_q, y_len_d, r_len_q, r_len_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [3:0]         flags_q, flags_d;
  logic [3:0]         alarm_in;
  logic [2:0]         nz_in, nz_q;
  logic               in_phase;
  logic               timer_load, timer_expire;
  logic [TIMER_W-1:0] timer_val;
  logic [TIMER_W-1:0] src_g, src_y, src_r;
  state_e             after_cur, round_first, start_first;

`ifdef LIGHT_SEQ_ABORT_ON_ALARM_EN
  logic aborted_q, aborted_d;
`endif

  // Gather alarm inputs into flag bit order.
  always_comb begin
    alarm_in              = '0;
    alarm_in[AlarmIdxA1]  = a1;
    alarm_in[AlarmIdxA2]  = a2;
    alarm_in[AlarmIdxA3]  = a3;
    alarm_in[AlarmIdxDec] = deception_out;
  end

  assign nz_in       = {red_len != '0, yellow_len != '0, green_len != '0};
  assign nz_q        = {r_len_q != '0, y_len_q != '0, g_len_q != '0};
  assign in_phase    = (state_q == StGreen) || (state_q == StYellow) || (state_q == StRed);
  assign after_cur   = next_phase(state_q, nz_q);
  assign round_first = next_phase(StIdle, nz_q);
  assign start_first = next_phase(StIdle, nz_in);

  // Next-state, latching and flag capture.
  always_comb begin
    state_d = state_q;
    g_len_d = g_len_q;
    y_len_d = y_len_q;
    r_len_d = r_len_q;
    round_d = round_q;
    flags_d = flags_q;
`ifdef LIGHT_SEQ_ABORT_ON_ALARM_EN
    aborted_d = aborted_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          g_len_d = green_len;
          y_len_d = yellow_len;
          r_len_d = red_len;
          round_d = (rounds == '0) ? ROUND_W'(1) : rounds;
          flags_d = '0;
`ifdef LIGHT_SEQ_ABORT_ON_ALARM_EN
          aborted_d = 1'b0;
`endif
          // start_first is StDone when every length is zero.
          state_d = start_first;
        end
      end
      StGreen, StYellow, StRed: begin
        flags_d = flags_q | alarm_in;
        if (timer_expire) begin
          if (after_cur != StDone) begin
            state_d = after_cur;
          end else if (round_q <= ROUND_W'(1)) begin
            state_d = StDone;
          end else begin
            round_d = round_q - ROUND_W'(1);
            state_d = round_first;
          end
        end
`ifdef LIGHT_SEQ_ABORT_ON_ALARM_EN
        if (alarm_in != '0) begin
          state_d   = StDone;
          aborted_d = 1'b1;
        end
`endif
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign src_g = (state_q == StIdle) ? green_len  : g_len_q;
  assign src_y = (state_q == StIdle) ? yellow_len : y_len_q;
  assign src_r = (state_q == StIdle) ? red_len    : r_len_q;

  // Reload the timer whenever a phase is entered, including re-entry of the same
  // phase at a round boundary when it is the only nonzero one.
  always_comb begin
    timer_load = ((state_q == StIdle) || (in_phase && timer_expire)) &&
                 ((state_d == StGreen) || (state_d == StYellow) || (state_d == StRed));
    timer_val  = '0;
    case (state_d)
      StGreen:  timer_val = src_g - TIMER_W'(1);
      StYellow: timer_val = src_y - TIMER_W'(1);
      StRed:    timer_val = src_r - TIMER_W'(1);
      default:  timer_val = '0;
    endcase
  end

  phase_timer #(
    .TIMER_W (TIMER_W)
  ) u_phase_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .expire   (timer_expire)
  );

  // State and latched configuration registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      g_len_q <= '0;
      y_len_q <= '0;
      r_len_q <= '0;
      round_q <= '0;
      flags_q <= '0;
`ifdef LIGHT_SEQ_ABORT_ON_ALARM_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      g_len_q <= g_len_d;
      y_len_q <= y_len_d;
      r_len_q <= r_len_d;
      round_q <= round_d;
      flags_q <= flags_d;
`ifdef LIGHT_SEQ_ABORT_ON_ALARM_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  // Outputs decode straight from registered state, so they are glitch-free.
  always_comb begin
    phase = PH_NONE;
    case (state_q)
      StGreen:  phase = PH_GREEN;
      StYellow: phase = PH_YELLOW;
      StRed:    phase = PH_RED;
      default:  phase = PH_NONE;
    endcase
  end

  assign green       = (state_q == StGreen);
  assign yellow      = (state_q == StYellow);
  assign red         = (state_q == StRed);
  assign busy        = in_phase;
  assign done        = (state_q == StDone);
  assign alarm_flags = flags_q;

`ifdef LIGHT_SEQ_ABORT_ON_ALARM_EN
  assign aborted = aborted_q;
`else
  assign aborted = 1'b0;
`endif

endmodule

// File: tb/tb_light_sequencer.sv
// Randomized bench for light_sequencer. The reference model expands each accepted
// start into a queue of per-cycle expected phases (1 green, 2 yellow, 3 red,
// 4 done) and pops one entry per clock.
module tb_light_sequencer;

  localparam int DoneCode = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [5:0] green_len = '0, yellow_len = '0, red_len = '0;
  logic [3:0] rounds = '0;
  logic       a1 = 1'b0, a2 = 1'b0, a3 = 1'b0, deception_out = 1'b0;
  logic       green, yellow, red, busy, done, aborted;
  logic [3:0] alarm_flags;
  logic [1:0] phase;

  int n_cmp = 0;
  int n_err = 0;

  int         exp_q[$];
  logic [3:0] m_flags = '0;
  logic       m_abort = 1'b0;

  always #5 clock = ~clock;

  light_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .green_len     (green_len),
    .yellow_len    (yellow_len),
    .red_len       (red_len),
    .rounds        (rounds),
    .a1            (a1),
    .a2            (a2),
    .a3            (a3),
    .deception_out (deception_out),
    .green         (green),
    .yellow        (yellow),
    .red           (red),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted),
    .alarm_flags   (alarm_flags),
    .phase         (phase)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model reaction to one rising edge, using the inputs present at that edge.
  task automatic model_edge();
    logic [3:0] al;
    logic       ab;
    int         nr;
    al = {deception_out, a3, a2, a1};
    ab = 1'b0;
    if (reset) begin
      exp_q.delete();
      m_flags = '0;
      m_abort = 1'b0;
    end else if (exp_q.size() == 0) begin
      if (start) begin
        m_flags = '0;
        m_abort = 1'b0;
        nr = (rounds == 0) ? 1 : int'(rounds);
        for (int r = 0; r < nr; r++) begin
          for (int i = 0; i < int'(green_len); i++) exp_q.push_back(1);
          for (int i = 0; i < int'(yellow_len); i++) exp_q.push_back(2);
          for (int i = 0; i < int'(red_len); i++) exp_q.push_back(3);
        end
        exp_q.push_back(DoneCode);
      end
    end else if (exp_q[0] == DoneCode) begin
      void'(exp_q.pop_front());
    end else begin
      m_flags = m_flags | al;
`ifdef LIGHT_SEQ_ABORT_ON_ALARM_EN
      ab = (al != 4'd0);
`endif
      if (ab) begin
        exp_q.delete();
        exp_q.push_back(DoneCode);
        m_abort = 1'b1;
      end else begin
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic check_outputs();
    int          cur;
    logic [1:0]  e_ph;
    logic [12:0] exp_v, got_v;
    cur   = (exp_q.size() != 0) ? exp_q[0] : 0;
    e_ph  = (cur >= 1 && cur <= 3) ? 2'(cur) : 2'd0;
    exp_v = {cur == 1, cur == 2, cur == 3, (cur >= 1 && cur <= 3), cur == DoneCode,
             m_abort, e_ph, m_flags};
    got_v = {green, yellow, red, busy, done, aborted, phase, alarm_flags};
    check_eq("outputs{g,y,r,busy,done,abt,ph,flags}", 32'(got_v), 32'(exp_v));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_outputs();
  endtask

  function automatic logic [5:0] rlen();
    case ($urandom % 10)
      0, 1, 2: rlen = 6'd0;
      3:       rlen = 6'd63;
      default: rlen = 6'($urandom_range(1, 5));
    endcase
  endfunction

  initial begin
    int cyc;
    int busy_cnt;
    int done_cnt;

    // Reset state.
    step();
    step();
    reset = 1'b0;
    step();

    // Two phases, red skipped, done on the 67th cycle.
    green_len = 6'd45; yellow_len = 6'd21; red_len = 6'd0; rounds = 4'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      step();
      cyc++;
    end
    check_eq("done_cycle_45_21", 32'(cyc), 32'd67);
    step();
    step();

    // Three rounds of G,G,Y,R,R,R.
    green_len = 6'd2; yellow_len = 6'd1; red_len = 6'd3; rounds = 4'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cnt++;
      green_len = 6'($urandom);  // must be ignored while busy
      step();
    end
    check_eq("busy_cycles_3rounds", 32'(busy_cnt), 32'd18);
    check_eq("done_pulses_3rounds", 32'(done_cnt), 32'd1);

    // All lengths zero.
    green_len = 6'd0; yellow_len = 6'd0; red_len = 6'd0; rounds = 4'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("zero_done", 32'(done), 32'd1);
    check_eq("zero_busy", 32'(busy), 32'd0);
    step();
    step();

    // Alarm a2 pulsed mid-green.
    green_len = 6'd10; yellow_len = 6'd3; red_len = 6'd2; rounds = 4'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    a2 = 1'b1;
    step();
    a2 = 1'b0;
    check_eq("flags_after_a2", 32'(alarm_flags), 32'd2);
    for (int i = 0; i < 20; i++) step();
    check_eq("flags_hold_idle", 32'(alarm_flags), 32'd2);

    // Reset in the middle of yellow, then a clean rerun.
    green_len = 6'd3; yellow_len = 6'd5; red_len = 6'd2; rounds = 4'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check_eq("in_yellow_before_reset", 32'(yellow), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 25; i++) step();

    // Start held high: G, DONE, IDLE, G, ...
    green_len = 6'd1; yellow_len = 6'd0; red_len = 6'd0; rounds = 4'd1;
    start = 1'b1;
    for (int i = 0; i < 12; i++) step();
    start = 1'b0;
    step();
    step();

    // Random traffic, inputs change every cycle.
    for (int i = 0; i < 3000; i++) begin
      start         = ($urandom % 4) == 0;
      reset         = ($urandom % 300) == 0;
      a1            = ($urandom % 60) == 0;
      a2            = ($urandom % 60) == 0;
      a3            = ($urandom % 60) == 0;
      deception_out = ($urandom % 60) == 0;
      green_len     = rlen();
      yellow_len    = rlen();
      red_len       = rlen();
      rounds        = 4'($urandom_range(0, 4));
      step();
    end
    reset = 1'b0;
    start = 1'b0;
    {a1, a2, a3, deception_out} = 4'd0;
    for (int i = 0; i < 5; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
